data_ram: RTL and testbench

DATA_RAM -- requirements
Module: data_ram

---
 rtl/data_ram.sv | 155 +++++++++++++++
 tb/tb_data_ram.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram.sv
// Byte-addressable 32-bit data RAM with sized/extended loads and a debug read port.
// Optional power-on clear sweep is compiled in with `define DATA_RAM_CLEAR_EN.
module data_ram #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W+1:0] addr,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              dvalid,
  output logic              err,
  output logic              busy,
  input  logic [ADDR_W-1:0] ext_a,
  output logic [31:0]       ext_d
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] widx_p0;
  logic [1:0]        off_p0;
  logic              accept_p0;
  logic              aligned_p0;
  logic [3:0]        wmask_p0;
  logic [31:0]       wdata_p0;
  logic [31:0]       rdata_p0;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;

  function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 1'b1;
      2'b01:   return ~off[0];
      2'b10:   return (off == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the source across all lanes lets the byte mask alone pick the target.
  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0] sz, input logic [1:0] off,
                                           input logic u, input logic [31:0] w);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    case (off)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h  = off[1] ? w[31:16] : w[15:0];
    sb = b;
    sh = h;
    case (sz)
      2'b00:   return u ? {24'h0, b} : 32'(sb);
      2'b01:   return u ? {16'h0, h} : 32'(sh);
      default: return w;
    endcase
  endfunction

  // Stage p0: request decode at the accepting edge
  assign widx_p0    = addr[ADDR_W+1:2];
  assign off_p0     = addr[1:0];
  assign accept_p0  = req & ~busy;
  assign aligned_p0 = is_aligned(size, off_p0);
  assign wmask_p0   = lane_mask(size, off_p0);
  assign wdata_p0   = lane_data(size, din);
  assign rdata_p0   = mem[widx_p0];
  assign ext_d      = mem[ext_a];

`ifdef DATA_RAM_CLEAR_EN
  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR && state_d == CLEAR)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && cnt_q == ADDR_W'(DEPTH - 1))
      state_d = IDLE;
  end

  assign busy    = (state_q == CLEAR);
  assign clr_we  = busy;
  assign clr_idx = cnt_q;
`else
  assign busy    = 1'b0;
  assign clr_we  = 1'b0;
  assign clr_idx = '0;
`endif

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (accept_p0 && aligned_p0 && we) begin
      for (int i = 0; i < 4; i++)
        if (wmask_p0[i])
          mem[widx_p0][8*i +: 8] <= wdata_p0[8*i +: 8];
    end
  end

  // Stage p1: registered load result and one-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout   <= '0;
      dvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      dvalid <= 1'b0;
      err    <= 1'b0;
      if (accept_p0) begin
        if (!aligned_p0) begin
          err <= 1'b1;
        end else if (!we) begin
          dout   <= load_ext(size, off_p0, uns, rdata_p0);
          dvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// Randomized scoreboard bench for data_ram against an array-based reference model.
module tb_data_ram;
  localparam int AW    = 5;
  localparam int DEPTH = 2 ** AW;
`ifdef DATA_RAM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, req, we, uns;
  logic [AW+1:0] addr;
  logic [1:0]    size;
  logic [31:0]   din, dout, ext_d;
  logic          dvalid, err, busy;
  logic [AW-1:0] ext_a;

  data_ram #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .size(size),
    .uns(uns), .din(din), .dout(dout), .dvalid(dvalid), .err(err), .busy(busy),
    .ext_a(ext_a), .ext_d(ext_d)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        dv, er, bz;
    logic [31:0] d;
    bit          chk_x;
    logic [31:0] xd;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] m_dout;
  bit          m_dv, m_er;
  int          clr_left;
  int          ext_fix = -1;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic bit legal(input int sz, input int off);
    return (sz == 0) || (sz == 1 && off % 2 == 0) || (sz == 2 && off == 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input int sz,
                                         input int off, input bit u);
    int w;
    logic [31:0] msk, v;
    if (sz == 2) return word;
    w   = (sz == 0) ? 8 : 16;
    msk = (32'h1 << w) - 1;
    v   = (word >> (off * 8)) & msk;
    if (!u && v[w-1]) v = v | ~msk;
    return v;
  endfunction

  task automatic model_edge();
    int idx, off, sz, w;
    logic [31:0] msk;
    m_dv = 0;
    m_er = 0;
    if (!rst_n) return;
    if (clr_left > 0) begin
      m_mem[DEPTH-clr_left]   = 32'h0;
      m_known[DEPTH-clr_left] = 1;
      clr_left--;
      return;
    end
    if (!req) return;
    idx = int'(addr) / 4;
    off = int'(addr) % 4;
    sz  = int'(size);
    if (!legal(sz, off)) begin
      m_er = 1;
      return;
    end
    w = (sz == 0) ? 8 : (sz == 1) ? 16 : 32;
    if (we) begin
      if (w == 32) begin
        m_mem[idx]   = din;
        m_known[idx] = 1;
      end else begin
        msk = (32'h1 << w) - 1;
        m_mem[idx] = (m_mem[idx] & ~(msk << (off * 8))) | ((din & msk) << (off * 8));
      end
    end else begin
      m_dout = m_load(m_mem[idx], sz, off, uns);
      m_dv   = 1;
    end
  endtask

  task automatic step();
    exp_t e;
    int nx;
    @(posedge clk);
    model_edge();
    nx      = (ext_fix >= 0) ? ext_fix : int'($urandom_range(DEPTH - 1, 0));
    e.dv    = m_dv;
    e.er    = m_er;
    e.bz    = (clr_left > 0);
    e.d     = m_dout;
    e.chk_x = m_known[nx];
    e.xd    = m_mem[nx];
    exp_q.push_back(e);
    #1 ext_a = AW'(nx);
  endtask

  task automatic acc(input bit w, input int a, input int sz, input bit u, input logic [31:0] d);
    req  = 1'b1;
    we   = w;
    addr = (AW+2)'(a);
    size = 2'(sz);
    uns  = u;
    din  = d;
    step();
    req = 1'b0;
  endtask

  task automatic do_reset();
    #5;
    rst_n    = 1'b0;
    m_dout   = 32'h0;
    m_dv     = 0;
    m_er     = 0;
    clr_left = CLR ? DEPTH : 0;
    step();
    #6 rst_n = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (dvalid !== e.dv || err !== e.er || busy !== e.bz || dout !== e.d ||
          (e.chk_x && ext_d !== e.xd)) begin
        n_fail++;
        $display("FAIL scoreboard: got dv=%b er=%b busy=%b dout=%h ext_d=%h want dv=%b er=%b busy=%b dout=%h ext_d=%h (ext checked %0b)",
                 dvalid, err, busy, dout, ext_d, e.dv, e.er, e.bz, e.d, e.xd, e.chk_x);
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; size = 2'b00;
    uns = 1'b0; din = 32'h0; ext_a = '0;
    m_dout = 32'h0;
    clr_left = CLR ? DEPTH : 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = 32'h0;
      m_known[i] = 0;
    end
    step();
    chk("reset_dout", dout, 32'h0);
    chk("reset_dvalid", 32'(dvalid), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    #6 rst_n = 1'b1;

`ifdef DATA_RAM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      req = 1'b1; we = 1'b0; addr = (AW+2)'($urandom); size = 2'(2); uns = 1'b0;
      step();
      chk("clear_busy", 32'(busy), (i < DEPTH - 1) ? 32'h1 : 32'h0);
      chk("clear_no_dvalid", 32'(dvalid), 32'h0);
    end
    req = 1'b0;
    acc(0, 'h04, 2, 0, 32'h0);
    chk("cleared_word4", dout, 32'h0);
    chk("cleared_word4_dvalid", 32'(dvalid), 32'h1);
`endif

    for (int i = 0; i < DEPTH; i++) acc(1, i * 4, 2, 0, $urandom);

    acc(1, 'h08, 2, 0, 32'hDEADBEEF);
    ext_fix = 2;
    acc(1, 'h09, 0, 0, 32'h00000011);
    chk("byte_store_ext", ext_d, 32'hDEAD11EF);
    ext_fix = -1;
    acc(0, 'h0B, 0, 0, 32'h0);
    chk("load_byte_signed", dout, 32'hFFFFFFDE);
    acc(0, 'h0B, 0, 1, 32'h0);
    chk("load_byte_unsigned", dout, 32'h000000DE);
    acc(0, 'h08, 1, 0, 32'h0);
    chk("load_half_signed", dout, 32'h000011EF);

    ext_fix = 3;
    acc(1, 'h0D, 1, 0, 32'hA5A5A5A5);
    chk("misaligned_half_err", 32'(err), 32'h1);
    chk("misaligned_half_dvalid", 32'(dvalid), 32'h0);
    chk("misaligned_half_ext", ext_d, m_mem[3]);
    acc(0, 'h0C, 3, 0, 32'h0);
    chk("illegal_size_err", 32'(err), 32'h1);
    chk("illegal_size_dout_held", dout, 32'h000011EF);
    ext_fix = -1;

    acc(1, 'h10, 2, 0, 32'h12345678);
    acc(0, 'h10, 2, 0, 32'h0);
    chk("back_to_back_load", dout, 32'h12345678);
    chk("back_to_back_dvalid", 32'(dvalid), 32'h1);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(9, 0) < 7) begin
        req  = 1'b1;
        we   = 1'($urandom);
        addr = (AW+2)'($urandom);
        size = ($urandom_range(15, 0) == 0) ? 2'b11 : 2'($urandom_range(2, 0));
        uns  = 1'($urandom);
        din  = $urandom;
      end else begin
        req = 1'b0;
      end
      step();
    end
    req = 1'b0;

`ifdef DATA_RAM_CLEAR_EN
    do_reset();
    for (int i = 0; i < 17; i++) step();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      req = 1'b1; we = 1'b1; addr = (AW+2)'($urandom); size = 2'(2); din = $urandom;
      step();
      chk("reclear_busy", 32'(busy), (i < DEPTH - 1) ? 32'h1 : 32'h0);
    end
    req = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      acc(0, i * 4, 2, 0, 32'h0);
      chk("reclear_word_zero", dout, 32'h0);
    end
`endif

    step();
    #6;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
